// File: rtl/alu_share_ctrl.sv
// Two-requester round-robin controller in front of a shared external ALU.
// Optional NZCV flag register is built when ALU_SHARE_FLAGS_EN is defined.
module alu_share_ctrl #(
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [2:0]       op0,
  input  logic [2:0]       op1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic             setf0,
  input  logic             setf1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] result,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_z,
  input  logic             alu_n,
  input  logic             alu_c,
  input  logic             alu_v
);

  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_TST = 3'b101;
  localparam logic [2:0] OP_CMP = 3'b110;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           state_q;
  logic             ptr_q;
  logic             win_q;
  logic             setf_q;
  logic             nowb_q;
  logic             gnt0_q, gnt1_q;
  logic             done0_q, done1_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] alu_a_q, alu_b_q;
  logic [2:0]       alu_op_q;

  logic             win_d;
  logic [2:0]       op_sel;
  logic [WIDTH-1:0] a_sel, b_sel;
  logic             setf_sel;
  logic             nowb_d;
  logic [2:0]       alu_op_d;

  // A lone request wins outright; a tie goes to the requester not served last.
  always_comb begin
    win_d    = (req0 && req1) ? ~ptr_q : req1;
    op_sel   = win_d ? op1 : op0;
    a_sel    = win_d ? a1 : a0;
    b_sel    = win_d ? b1 : b0;
    setf_sel = win_d ? setf1 : setf0;
    nowb_d   = (op_sel == OP_TST) || (op_sel == OP_CMP);
    case (op_sel)
      OP_TST:  alu_op_d = OP_AND;
      OP_CMP:  alu_op_d = OP_SUB;
      default: alu_op_d = op_sel;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= 1'b1;
      win_q    <= 1'b0;
      setf_q   <= 1'b0;
      nowb_q   <= 1'b0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      result_q <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= 3'b000;
    end else begin
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req0 || req1) begin
            win_q    <= win_d;
            ptr_q    <= win_d;
            gnt0_q   <= ~win_d;
            gnt1_q   <= win_d;
            alu_op_q <= alu_op_d;
            alu_a_q  <= a_sel;
            alu_b_q  <= b_sel;
            setf_q   <= setf_sel;
            nowb_q   <= nowb_d;
            state_q  <= EXEC;
          end
        end
        EXEC: begin
          if (!nowb_q) result_q <= alu_out;
          state_q <= DONE;
        end
        DONE: begin
          done0_q <= ~win_q;
          done1_q <= win_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt0   = gnt0_q;
  assign gnt1   = gnt1_q;
  assign done0  = done0_q;
  assign done1  = done1_q;
  assign result = result_q;
  assign alu_a  = alu_a_q;
  assign alu_b  = alu_b_q;
  assign alu_op = alu_op_q;

`ifdef ALU_SHARE_FLAGS_EN
  logic [3:0] flags_q;

  // TST/CMP exist only to set flags, so they update regardless of setf.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= 4'b0000;
    end else if (state_q == EXEC && (setf_q || nowb_q)) begin
      flags_q <= {alu_n, alu_z, alu_c, alu_v};
    end
  end

  assign flag_n = flags_q[3];
  assign flag_z = flags_q[2];
  assign flag_c = flags_q[1];
  assign flag_v = flags_q[0];
`else
  logic unused_flag_inputs;
  assign unused_flag_inputs = ^{setf_q, alu_n, alu_z, alu_c, alu_v};

  assign flag_n = 1'b0;
  assign flag_z = 1'b0;
  assign flag_c = 1'b0;
  assign flag_v = 1'b0;
`endif

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: drives a behavioural ALU and checks against a spec-level model.
module tb_alu_share_ctrl;

  localparam int W = 33;
  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, RSB = 3'b010, AND_ = 3'b011;
  localparam logic [2:0] NOT_ = 3'b100, TST = 3'b101, CMP = 3'b110, MOV = 3'b111;
`ifdef ALU_SHARE_FLAGS_EN
  localparam bit FLAGS_EN = 1'b1;
`else
  localparam bit FLAGS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0 = 0, req1 = 0, setf0 = 0, setf1 = 0;
  logic [2:0] op0 = 0, op1 = 0;
  logic [W-1:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
  logic gnt0, gnt1, done0, done1, flag_n, flag_z, flag_c, flag_v;
  logic [W-1:0] result, alu_a, alu_b, alu_out;
  logic [2:0] alu_op;
  logic alu_z, alu_n, alu_c, alu_v;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int gnt_cyc = 0, gnt_cyc_prev = 0;
  logic [W-1:0] m_result = '0;
  logic [3:0]   m_flags = '0;
  bit           m_ptr = 1'b1;

  alu_share_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .setf0(setf0), .setf1(setf1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .result(result),
    .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_z(alu_z), .alu_n(alu_n), .alu_c(alu_c), .alu_v(alu_v)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Returns {n, z, c, v, out}; c is carry for ADD and borrow for SUB/RSB.
  function automatic logic [W+3:0] alu_fn(input logic [2:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic [W:0] s;
    logic [W-1:0] o;
    logic c, v;
    c = 1'b0;
    v = 1'b0;
    s = '0;
    case (op)
      ADD: begin
        s = {1'b0, a} + {1'b0, b};
        o = s[W-1:0];
        c = s[W];
        v = (a[W-1] == b[W-1]) && (o[W-1] != a[W-1]);
      end
      SUB: begin
        o = a - b;
        c = (a < b);
        v = (a[W-1] != b[W-1]) && (o[W-1] != a[W-1]);
      end
      RSB: begin
        o = b - a;
        c = (b < a);
        v = (a[W-1] != b[W-1]) && (o[W-1] != b[W-1]);
      end
      AND_: o = a & b;
      NOT_: o = ~a;
      MOV:  o = b;
      default: begin
        o = a ^ {b[W-2:0], 1'b1};
        c = 1'b1;
        v = 1'b1;
      end
    endcase
    return {o[W-1], (o == '0), c, v, o};
  endfunction

  logic [W+3:0] stub;
  always_comb stub = alu_fn(alu_op, alu_a, alu_b);
  assign alu_out = stub[W-1:0];
  assign alu_n = stub[W+3];
  assign alu_z = stub[W+2];
  assign alu_c = stub[W+1];
  assign alu_v = stub[W];

  function automatic logic [W-1:0] rnd();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    case ($urandom_range(0, 4))
      0: return '0;
      1: return '1;
      2: return W'($urandom_range(0, 15));
      default: return t[W-1:0];
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_gnt"}, {gnt1, gnt0}, 0);
    chk({tag, "_done"}, {done1, done0}, 0);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_flags"}, {flag_n, flag_z, flag_c, flag_v}, 0);
    chk({tag, "_alu_ab"}, {alu_a, alu_b}, 0);
    chk({tag, "_alu_op"}, alu_op, 0);
  endtask

  // Waits for a grant, checks it and the ALU drive, then checks writeback and done.
  task automatic expect_txn(input int win, input int lat, input bit use_exp,
                            input logic [W-1:0] exp_res, input logic [3:0] exp_fl);
    int n;
    logic [2:0] op, rop;
    logic [W-1:0] a, b;
    bit sf, other_req;
    logic [W+3:0] r;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(gnt0 || gnt1) && n < 20);
    chk("gnt_latency", n, lat);
    if (!(gnt0 || gnt1)) return;
    gnt_cyc_prev = gnt_cyc;
    gnt_cyc = cyc;
    chk("gnt_winner", {gnt1, gnt0}, (win == 1) ? 2'b10 : 2'b01);
    op = (win == 1) ? op1 : op0;
    a  = (win == 1) ? a1 : a0;
    b  = (win == 1) ? b1 : b0;
    sf = (win == 1) ? setf1 : setf0;
    rop = (op == TST) ? AND_ : (op == CMP) ? SUB : op;
    chk("alu_op", alu_op, rop);
    chk("alu_a", alu_a, a);
    chk("alu_b", alu_b, b);
    r = alu_fn(rop, a, b);
    if (use_exp) begin
      m_result = exp_res;
      m_flags  = FLAGS_EN ? exp_fl : 4'b0000;
    end else begin
      if (op != TST && op != CMP) m_result = r[W-1:0];
      if (FLAGS_EN && (sf || op == TST || op == CMP)) m_flags = r[W+3:W];
    end
    m_ptr = (win == 1);
    // After its grant the winner may change anything; an idle loser may too.
    if (win == 1) begin
      req1 = 0; op1 = 3'($urandom); a1 = rnd(); b1 = rnd(); setf1 = 1'($urandom);
      other_req = req0;
    end else begin
      req0 = 0; op0 = 3'($urandom); a0 = rnd(); b0 = rnd(); setf0 = 1'($urandom);
      other_req = req1;
    end
    if (!other_req) begin
      if (win == 1) begin op0 = 3'($urandom); a0 = rnd(); b0 = rnd(); setf0 = 1'($urandom); end
      else begin op1 = 3'($urandom); a1 = rnd(); b1 = rnd(); setf1 = 1'($urandom); end
    end
    @(negedge clk);
    chk("result", result, m_result);
    chk("flags", {flag_n, flag_z, flag_c, flag_v}, m_flags);
    chk("done_early", {done1, done0}, 0);
    @(negedge clk);
    chk("done", {done1, done0}, (win == 1) ? 2'b10 : 2'b01);
    $display("txn win=%0d op=%0d a=%0h b=%0h setf=%0d -> result=%0h flags=%b", win, op, a, b,
             sf, result, {flag_n, flag_z, flag_c, flag_v});
  endtask

  task automatic drive(input int who, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input bit sf);
    if (who == 1) begin req1 = 1; op1 = op; a1 = a; b1 = b; setf1 = sf; end
    else begin req0 = 1; op0 = op; a0 = a; b0 = b; setf0 = sf; end
  endtask

  task automatic do_reset();
    @(negedge clk);
    req0 = 0; req1 = 0;
    rst = 1;
    #1;
    chk_cleared("reset");
    @(negedge clk);
    rst = 0;
    m_result = '0; m_flags = '0; m_ptr = 1'b1;
  endtask

  typedef struct {
    int          who;
    logic [2:0]  op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    bit          setf;
    logic [W-1:0] res;
    logic [3:0]  fl;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    tbl[0] = '{0, ADD,  33'd5,           33'd3,           1'b0, 33'd8,           4'b0000};
    tbl[1] = '{1, CMP,  33'd7,           33'd7,           1'b0, 33'd8,           4'b0100};
    tbl[2] = '{0, SUB,  33'd0,           33'd1,           1'b1, 33'h1FFFFFFFF,   4'b1010};
    tbl[3] = '{1, AND_, 33'h1000000FF,   33'h1FFFF0F0F,   1'b1, 33'h10000000F,   4'b1000};
    tbl[4] = '{0, TST,  33'd5,           33'd2,           1'b0, 33'h10000000F,   4'b0100};
    tbl[5] = '{1, NOT_, 33'd0,           33'd9,           1'b0, 33'h1FFFFFFFF,   4'b0100};
    tbl[6] = '{0, RSB,  33'd3,           33'd10,          1'b1, 33'd7,           4'b0000};
    tbl[7] = '{1, MOV,  33'd4,           33'd0,           1'b1, 33'd0,           4'b0100};
    tbl[8] = '{0, ADD,  33'h1FFFFFFFF,   33'd1,           1'b1, 33'd0,           4'b0110};
    tbl[9] = '{1, ADD,  33'h0FFFFFFFF,   33'd1,           1'b1, 33'h100000000,   4'b1001};

    repeat (2) @(negedge clk);
    chk_cleared("por");
    rst = 0;

    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].who, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].setf);
      expect_txn(tbl[i].who, 1, 1'b1, tbl[i].res, tbl[i].fl);
    end

    // Simultaneous requests straight after reset: requester 0 first, 3 cycles apart.
    do_reset();
    drive(0, ADD, 33'd1, 33'd1, 1'b0);
    drive(1, SUB, 33'd9, 33'd4, 1'b0);
    expect_txn(0, 1, 1'b1, 33'd2, 4'b0000);
    expect_txn(1, 1, 1'b1, 33'd5, 4'b0000);
    chk("gnt_spacing", gnt_cyc - gnt_cyc_prev, 3);

    // Requester 1 served alone, then a tie goes to requester 0.
    drive(1, MOV, 33'd0, 33'd21, 1'b0);
    expect_txn(1, 1, 1'b0, '0, '0);
    drive(0, ADD, 33'd2, 33'd2, 1'b0);
    drive(1, ADD, 33'd3, 33'd3, 1'b0);
    expect_txn(0, 1, 1'b0, '0, '0);
    expect_txn(1, 1, 1'b0, '0, '0);

    // Borrow case, then reset lands mid-EXEC of the following op.
    drive(0, SUB, 33'd0, 33'd1, 1'b1);
    expect_txn(0, 1, 1'b1, 33'h1FFFFFFFF, 4'b1010);
    drive(0, ADD, 33'd2, 33'd2, 1'b1);
    @(negedge clk);
    chk("abort_gnt", gnt0, 1'b1);
    #2 rst = 1;
    #1 chk_cleared("abort");
    @(negedge clk);
    rst = 0;
    req0 = 0;
    m_result = '0; m_flags = '0; m_ptr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_done", {done1, done0}, 0);
      chk("abort_result", result, 0);
    end

    // Randomized traffic: one requester or both, checked against the model.
    for (int i = 0; i < 60; i++) begin
      int mode;
      int w;
      mode = $urandom_range(0, 2);
      if (mode == 2) begin
        drive(0, 3'($urandom), rnd(), rnd(), 1'($urandom));
        drive(1, 3'($urandom), rnd(), rnd(), 1'($urandom));
        w = m_ptr ? 0 : 1;
        expect_txn(w, 1, 1'b0, '0, '0);
        expect_txn(1 - w, 1, 1'b0, '0, '0);
      end else begin
        drive(mode, 3'($urandom), rnd(), rnd(), 1'($urandom));
        expect_txn(mode, 1, 1'b0, '0, '0);
      end
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
